// File: rtl/mmu_rx_bd_rcv.sv
// Receive side of the mmu_tx -> mmu_rx BD stream: beat checking, show-ahead BD FIFO, DFX counters.
// Optional sequence-number check is enabled by defining MMU_RX_BD_SN_CHK_EN.
//
// state | meaning
// IDLE  | each accepted beat is checked and stored if good
// DROP  | inside a multi-beat packet; every beat is dropped until tlast
module mmu_rx_bd_rcv #(
    parameter int         A_DTH       = 5,
    parameter logic [5:0] AFULL_LEVEL = 6'd24,
    parameter logic [7:0] OPC_WR      = 8'h01,
    parameter logic [7:0] OPC_RD      = 8'h02
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic [511:0] bd2rx_m_axis_rq_tdata,
    input  logic [59:0]  bd2rx_m_axis_rq_tuser,
    input  logic         bd2rx_m_axis_rq_tlast,
    input  logic [63:0]  bd2rx_m_axis_rq_tkeep,
    input  logic         bd2rx_m_axis_rq_tvalid,
    output logic         bd2rx_m_axis_rq_tready,
    input  logic         rx_bd_rd,
    output logic         rx_bd_ef,
    output logic [511:0] rx_bd_rdata,
    output logic         rx_bd_type,
    output logic [31:0]  rx_wr_bd_cnt,
    output logic [31:0]  rx_rd_bd_cnt,
    output logic [15:0]  rx_bd_drop_cnt,
    output logic [15:0]  rx_bd_sta,
    output logic [15:0]  rx_bd_err
);

    localparam int DEPTH = 1 << A_DTH;
    localparam int CW    = A_DTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [512:0]     mem [DEPTH];
    logic [A_DTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic [512:0]     head;
    logic             acc, keep_ok, opc_wr, opc_ok;
    logic             good, drop, full, wr_en, pop;
    logic [4:0]       err_lo;
    logic             sn_err;
    logic [5:0]       err_r;
    logic             unused_tuser;

    assign unused_tuser = ^bd2rx_m_axis_rq_tuser;

    assign acc     = bd2rx_m_axis_rq_tvalid & bd2rx_m_axis_rq_tready & ~rst;
    assign keep_ok = &bd2rx_m_axis_rq_tkeep;
    assign opc_wr  = (bd2rx_m_axis_rq_tdata[7:0] == OPC_WR);
    assign opc_ok  = opc_wr | (bd2rx_m_axis_rq_tdata[7:0] == OPC_RD);

    assign rx_bd_ef = (count == '0);
    assign full     = (count == CW'(DEPTH));
    // Full-FIFO writes are discarded; tready margin should make this unreachable.
    assign wr_en    = good & ~full;
    assign pop      = rx_bd_rd & ~rx_bd_ef;

    always_comb begin
        state_nxt = state;
        good      = 1'b0;
        drop      = 1'b0;
        err_lo    = '0;
        if (acc) begin
            case (state)
                IDLE: begin
                    if (bd2rx_m_axis_rq_tlast & keep_ok & opc_ok) begin
                        good = 1'b1;
                    end else begin
                        drop = 1'b1;
                        if (!bd2rx_m_axis_rq_tlast) begin
                            err_lo[0] = 1'b1;
                            state_nxt = DROP;
                        end
                        if (!keep_ok) err_lo[1] = 1'b1;
                        if (!opc_ok)  err_lo[2] = 1'b1;
                    end
                end
                DROP: begin
                    drop = 1'b1;
                    if (bd2rx_m_axis_rq_tlast) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
        err_lo[3] = rx_bd_rd & rx_bd_ef;
        err_lo[4] = good & full;
    end

    always_comb begin
        count_nxt = count;
        if (wr_en & ~pop)
            count_nxt = count + CW'(1);
        else if (~wr_en & pop)
            count_nxt = count - CW'(1);
    end

`ifdef MMU_RX_BD_SN_CHK_EN
    logic [10:0] sn_ref;
    logic        sn_vld;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sn_ref <= '0;
            sn_vld <= 1'b0;
        end else if (good) begin
            sn_ref <= bd2rx_m_axis_rq_tdata[18:8];
            sn_vld <= 1'b1;
        end
    end

    assign sn_err = good & sn_vld & (bd2rx_m_axis_rq_tdata[18:8] != sn_ref + 11'd1);
`else
    assign sn_err = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state                  <= IDLE;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            count                  <= '0;
            bd2rx_m_axis_rq_tready <= 1'b0;
            rx_wr_bd_cnt           <= '0;
            rx_rd_bd_cnt           <= '0;
            rx_bd_drop_cnt         <= '0;
            err_r                  <= '0;
        end else begin
            state                  <= state_nxt;
            count                  <= count_nxt;
            bd2rx_m_axis_rq_tready <= (count_nxt < CW'(AFULL_LEVEL));
            if (wr_en)
                wr_ptr <= wr_ptr + A_DTH'(1);
            if (pop)
                rd_ptr <= rd_ptr + A_DTH'(1);
            if (wr_en & opc_wr)
                rx_wr_bd_cnt <= rx_wr_bd_cnt + 32'd1;
            if (wr_en & ~opc_wr)
                rx_rd_bd_cnt <= rx_rd_bd_cnt + 32'd1;
            if (drop && rx_bd_drop_cnt != 16'hffff)
                rx_bd_drop_cnt <= rx_bd_drop_cnt + 16'd1;
            err_r <= err_r | {sn_err, err_lo};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en)
            mem[wr_ptr] <= {opc_wr, bd2rx_m_axis_rq_tdata};
    end

    assign head        = mem[rd_ptr];
    assign rx_bd_rdata = rx_bd_ef ? '0 : head[511:0];
    assign rx_bd_type  = ~rx_bd_ef & head[512];
    assign rx_bd_err   = {10'b0, err_r};
    assign rx_bd_sta   = {bd2rx_m_axis_rq_tready, rx_bd_ef, full, (state == DROP),
                          6'b0, 6'(count)};

endmodule

// File: tb/tb_mmu_rx_bd_rcv.sv
// Directed, table-driven bench for mmu_rx_bd_rcv with hand-written corner-case sequences.
module tb_mmu_rx_bd_rcv;

    localparam logic [7:0]  W  = 8'h01;
    localparam logic [7:0]  R  = 8'h02;
    localparam logic [63:0] KA = 64'hffff_ffff_ffff_ffff;

    logic         clk_sys = 1'b0;
    logic         rst;
    logic [511:0] tdata;
    logic [59:0]  tuser;
    logic         tlast;
    logic [63:0]  tkeep;
    logic         tvalid;
    logic         tready;
    logic         rd;
    logic         ef;
    logic [511:0] rdata;
    logic         btype;
    logic [31:0]  wr_cnt, rd_cnt;
    logic [15:0]  drop_cnt, sta, err;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    mmu_rx_bd_rcv dut (
        .clk_sys                (clk_sys),
        .rst                    (rst),
        .bd2rx_m_axis_rq_tdata  (tdata),
        .bd2rx_m_axis_rq_tuser  (tuser),
        .bd2rx_m_axis_rq_tlast  (tlast),
        .bd2rx_m_axis_rq_tkeep  (tkeep),
        .bd2rx_m_axis_rq_tvalid (tvalid),
        .bd2rx_m_axis_rq_tready (tready),
        .rx_bd_rd               (rd),
        .rx_bd_ef               (ef),
        .rx_bd_rdata            (rdata),
        .rx_bd_type             (btype),
        .rx_wr_bd_cnt           (wr_cnt),
        .rx_rd_bd_cnt           (rd_cnt),
        .rx_bd_drop_cnt         (drop_cnt),
        .rx_bd_sta              (sta),
        .rx_bd_err              (err)
    );

    typedef struct {
        logic        valid;
        logic [7:0]  opc;
        logic        last;
        logic [63:0] keep;
        logic [15:0] tag;
        logic        rd;
        logic        e_ef;
        logic        e_type;
        logic [15:0] e_tag;
        logic [5:0]  e_fill;
        logic [31:0] e_wr;
        logic [31:0] e_rd;
        logic [15:0] e_drop;
        logic [15:0] e_err;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [511:0] mk_bd(input logic [7:0] opc, input logic [10:0] sn,
                                           input logic [15:0] tag);
        logic [511:0] d;
        d          = '0;
        d[7:0]     = opc;
        d[18:8]    = sn;
        d[511:496] = tag;
        return d;
    endfunction

    task automatic drive(input logic v, input logic [7:0] opc, input logic [10:0] sn,
                         input logic last, input logic [63:0] keep, input logic [15:0] tag,
                         input logic r);
        tvalid = v;
        tdata  = mk_bd(opc, sn, tag);
        tlast  = last;
        tkeep  = keep;
        rd     = r;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 11'd0, 1'b0, '0, 16'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        chk("rst tready", tready, 0);
        chk("rst ef", ef, 1);
        chk("rst rdata", rdata[63:0] | rdata[511:448], 0);
        chk("rst type", btype, 0);
        chk("rst wr_cnt", wr_cnt, 0);
        chk("rst rd_cnt", rd_cnt, 0);
        chk("rst drop", drop_cnt, 0);
        chk("rst err", err, 0);
        chk("rst sta", sta, 16'h4000);
        rst = 1'b0;
        step();
        step();
        chk("post-rst tready", tready, 1);
    endtask

    function automatic vec_t v(input logic valid, input logic [7:0] opc, input logic last,
                               input logic [63:0] keep, input logic [15:0] tag, input logic r,
                               input logic e_ef, input logic e_type, input logic [15:0] e_tag,
                               input logic [5:0] e_fill, input logic [31:0] e_wr,
                               input logic [31:0] e_rd, input logic [15:0] e_drop,
                               input logic [15:0] e_err);
        vec_t x;
        x.valid = valid; x.opc = opc; x.last = last; x.keep = keep; x.tag = tag; x.rd = r;
        x.e_ef = e_ef; x.e_type = e_type; x.e_tag = e_tag; x.e_fill = e_fill;
        x.e_wr = e_wr; x.e_rd = e_rd; x.e_drop = e_drop; x.e_err = e_err;
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] sn_exp[5];
        int          sn_val[5];
        int          model;
        int          nt;
        int          k;
        int          guard;
        logic        acc;

        tuser = '0;
        rst   = 1'b1;
        idle();

        // 5 writes, 3 reads, then pop all; then keep/opcode errors
        vt[0]  = v(1, W, 1, KA,  1, 0,  0, 1, 1, 1, 1, 0, 0, 0);
        vt[1]  = v(1, W, 1, KA,  2, 0,  0, 1, 1, 2, 2, 0, 0, 0);
        vt[2]  = v(1, W, 1, KA,  3, 0,  0, 1, 1, 3, 3, 0, 0, 0);
        vt[3]  = v(1, W, 1, KA,  4, 0,  0, 1, 1, 4, 4, 0, 0, 0);
        vt[4]  = v(1, W, 1, KA,  5, 0,  0, 1, 1, 5, 5, 0, 0, 0);
        vt[5]  = v(1, R, 1, KA,  6, 0,  0, 1, 1, 6, 5, 1, 0, 0);
        vt[6]  = v(1, R, 1, KA,  7, 0,  0, 1, 1, 7, 5, 2, 0, 0);
        vt[7]  = v(1, R, 1, KA,  8, 0,  0, 1, 1, 8, 5, 3, 0, 0);
        vt[8]  = v(0, W, 1, KA,  0, 1,  0, 1, 2, 7, 5, 3, 0, 0);
        vt[9]  = v(0, W, 1, KA,  0, 1,  0, 1, 3, 6, 5, 3, 0, 0);
        vt[10] = v(0, W, 1, KA,  0, 1,  0, 1, 4, 5, 5, 3, 0, 0);
        vt[11] = v(0, W, 1, KA,  0, 1,  0, 1, 5, 4, 5, 3, 0, 0);
        vt[12] = v(0, W, 1, KA,  0, 1,  0, 0, 6, 3, 5, 3, 0, 0);
        vt[13] = v(0, W, 1, KA,  0, 1,  0, 0, 7, 2, 5, 3, 0, 0);
        vt[14] = v(0, W, 1, KA,  0, 1,  0, 0, 8, 1, 5, 3, 0, 0);
        vt[15] = v(0, W, 1, KA,  0, 1,  1, 0, 0, 0, 5, 3, 0, 0);
        vt[16] = v(1, W, 1, 64'h0000_ffff_ffff_ffff, 9, 0, 1, 0, 0, 0, 5, 3, 1, 16'h0002);
        vt[17] = v(1, 8'h07, 1, KA, 10, 0, 1, 0, 0, 0, 5, 3, 2, 16'h0006);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(vt[i].valid, vt[i].opc, 11'd0, vt[i].last, vt[i].keep, vt[i].tag, vt[i].rd);
            step();
            chk($sformatf("v%0d ef", i), ef, vt[i].e_ef);
            chk($sformatf("v%0d fill", i), sta[5:0], vt[i].e_fill);
            chk($sformatf("v%0d wr_cnt", i), wr_cnt, vt[i].e_wr);
            chk($sformatf("v%0d rd_cnt", i), rd_cnt, vt[i].e_rd);
            chk($sformatf("v%0d drop", i), drop_cnt, vt[i].e_drop);
            chk($sformatf("v%0d err", i), err, vt[i].e_err);
            if (!vt[i].e_ef) begin
                chk($sformatf("v%0d type", i), btype, vt[i].e_type);
                chk($sformatf("v%0d tag", i), rdata[511:496], vt[i].e_tag);
            end
        end
        idle();

        // back-pressure: stream writes until tready drops
        do_reset();
        model = 0;
        nt    = 1;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, W, 11'd0, 1'b1, KA, 16'(nt), 1'b0);
            acc = tready;
            step();
            if (acc) begin
                model++;
                nt++;
            end
        end
        idle();
        chk("t2 fill model", sta[5:0], 6'(model));
        chk("t2 fill 24", sta[5:0], 24);
        chk("t2 tready", tready, 0);
        chk("t2 full", sta[13], 0);
        chk("t2 err4", err[4], 0);
        k     = 1;
        guard = 0;
        while (!ef && guard < 40) begin
            chk($sformatf("t2 pop%0d tag", k), rdata[511:496], 16'(k));
            rd = 1'b1;
            step();
            k++;
            guard++;
        end
        rd = 1'b0;
        chk("t2 popped", k - 1, 24);
        chk("t2 ef", ef, 1);
        chk("t2 err", err, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W, 11'd0, 1'b1, KA, 16'(100 + i), 1'b0);
            step();
        end
        idle();
        chk("t2 resume fill", sta[5:0], 3);
        chk("t2 resume head", rdata[511:496], 100);
        chk("t2 resume wr", wr_cnt, 27);
        chk("t2 resume tready", tready, 1);

        // multi-beat packet is dropped, DROP state until tlast
        do_reset();
        drive(1'b1, W, 11'd0, 1'b0, KA, 16'd40, 1'b0);
        step();
        chk("t3 b1 drop", drop_cnt, 1);
        chk("t3 b1 err", err, 1);
        chk("t3 b1 state", sta[12], 1);
        drive(1'b1, W, 11'd0, 1'b0, KA, 16'd41, 1'b0);
        step();
        chk("t3 b2 drop", drop_cnt, 2);
        chk("t3 b2 state", sta[12], 1);
        drive(1'b1, W, 11'd0, 1'b1, KA, 16'd42, 1'b0);
        step();
        chk("t3 b3 drop", drop_cnt, 3);
        chk("t3 b3 state", sta[12], 0);
        chk("t3 b3 ef", ef, 1);
        drive(1'b1, W, 11'd0, 1'b1, KA, 16'd50, 1'b0);
        step();
        idle();
        chk("t3 good fill", sta[5:0], 1);
        chk("t3 good head", rdata[511:496], 50);
        chk("t3 good wr", wr_cnt, 1);
        chk("t3 good drop", drop_cnt, 3);
        chk("t3 good err", err, 1);

        // simultaneous write + pop, empty read, reset with data
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W, 11'd0, 1'b1, KA, 16'(i + 1), 1'b0);
            step();
        end
        chk("t5 fill4", sta[5:0], 4);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, W, 11'd0, 1'b1, KA, 16'(i + 5), 1'b1);
            step();
            chk($sformatf("t5 wrpop%0d fill", i), sta[5:0], 4);
            chk($sformatf("t5 wrpop%0d head", i), rdata[511:496], 16'(i + 2));
        end
        idle();
        chk("t5 wr_cnt", wr_cnt, 14);
        rd = 1'b1;
        repeat (4) step();
        chk("t5 drained ef", ef, 1);
        chk("t5 no err3 yet", err[3], 0);
        step();
        rd = 1'b0;
        chk("t5 empty rd err", err, 16'h0008);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, R, 11'd0, 1'b1, KA, 16'(i + 60), 1'b0);
            step();
        end
        idle();
        chk("t5 refill", sta[5:0], 4);
        do_reset();

        // sequence numbers across the 2047 -> 0 wrap and one jump
        sn_val = '{2046, 2047, 0, 5, 6};
`ifdef MMU_RX_BD_SN_CHK_EN
        sn_exp = '{16'h0, 16'h0, 16'h0, 16'h20, 16'h20};
`else
        sn_exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
`endif
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W, 11'(sn_val[i]), 1'b1, KA, 16'(i + 1), 1'b0);
            step();
            chk($sformatf("t6 sn%0d err", sn_val[i]), err, sn_exp[i]);
        end
        idle();
        chk("t6 fill", sta[5:0], 5);
        chk("t6 drop", drop_cnt, 0);
        chk("t6 head sn", rdata[18:8], 2046);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
